// File: rtl/tone_monitor_if.sv
// -----------------------------------------------------------------------------
// tone_monitor_if
// Sample bus and result handshake between the tone source, the tone monitor
// and the control-side consumer.
//   en       sample strobe, din is meaningful only when en=1
//   din      signed 16-bit sample
//   ack      result acknowledge from the consumer
//   period   samples between the last two triggers (unsigned)
//   peak     signed maximum sample over the measured window
//   valid    result pending
//   overrun  sticky: a pending result was overwritten
//   timeout  current result is a timeout report
// Modports: master = stimulus/consumer side, slave = tone_monitor.
// -----------------------------------------------------------------------------
interface tone_monitor_if;
    logic        en;
    logic [15:0] din;
    logic        ack;
    logic [15:0] period;
    logic [15:0] peak;
    logic        valid;
    logic        overrun;
    logic        timeout;

    modport master (
        output en, din, ack,
        input  period, peak, valid, overrun, timeout
    );

    modport slave (
        input  en, din, ack,
        output period, peak, valid, overrun, timeout
    );
endinterface

// File: rtl/tone_monitor.sv
// -----------------------------------------------------------------------------
// tone_monitor
// Watches a strobed signed sample stream, detects positive-going zero crossings
// with hysteresis (arm at <= -HYST, trigger at >= +HYST), measures the period
// in samples between consecutive triggers and the positive peak over each
// period, and hands results to the consumer via valid/ack with overrun flag.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    tone_monitor_if.slave (en, din, ack in; period, peak, valid,
//          overrun, timeout out -- all outputs registered)
//
// Optional feature macro: TONE_MONITOR_TIMEOUT_EN
//   defined   : 65535 samples without a trigger while locked publishes a
//               timeout report (period=0, timeout=1) and drops back to SEEK.
//   undefined : timeout output tied low, the counter just saturates.
// -----------------------------------------------------------------------------
module tone_monitor #(
    parameter int HYST = 4096
) (
    input  logic           clk,
    input  logic           rst_n,
    tone_monitor_if.slave  bus
);

    typedef enum logic [0:0] {
        SEEK = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic signed [15:0] HYST_POS = 16'(HYST);
    localparam logic signed [15:0] HYST_NEG = -HYST_POS;

    state_t             state_r;
    logic               armed_r;
    logic        [15:0] cnt_r;
    logic signed [15:0] pk_r;
    logic        [15:0] period_r;
    logic signed [15:0] peak_r;
    logic               valid_r;
    logic               overrun_r;

    logic signed [15:0] din_s;
    logic               arm_hit_s;
    logic               trig_s;
    logic        [15:0] cnt_inc_s;
    logic signed [15:0] pk_max_s;
    logic               publish_s;
    logic        [15:0] pub_period_s;
    logic signed [15:0] pub_peak_s;
`ifdef TONE_MONITOR_TIMEOUT_EN
    logic               timeout_r;
    logic               timeout_hit_s;
    logic               pub_timeout_s;
`endif

    // Crossing detection and saturating counter / running-max next values.
    always_comb begin
        din_s     = $signed(bus.din);
        arm_hit_s = 1'b0;
        trig_s    = 1'b0;
        if (bus.en) begin
            arm_hit_s = (din_s <= HYST_NEG);
            trig_s    = armed_r && (din_s >= HYST_POS);
        end else begin
            arm_hit_s = 1'b0;
            trig_s    = 1'b0;
        end
        // period = cnt+1 saturating is the same value as the saturating increment
        if (cnt_r == 16'hFFFF) begin
            cnt_inc_s = 16'hFFFF;
        end else begin
            cnt_inc_s = cnt_r + 16'd1;
        end
        if (din_s > pk_r) begin
            pk_max_s = din_s;
        end else begin
            pk_max_s = pk_r;
        end
    end

    // Decide whether this cycle publishes a result and with which contents.
    always_comb begin
        publish_s    = 1'b0;
        pub_period_s = 16'd0;
        pub_peak_s   = 16'sd0;
`ifdef TONE_MONITOR_TIMEOUT_EN
        pub_timeout_s = 1'b0;
        // cnt_r==FFFE on a non-trigger sample means cnt reaches FFFF now
        timeout_hit_s = bus.en && (state_r == LOCK) && !trig_s && (cnt_r == 16'hFFFE);
`endif
        if ((state_r == LOCK) && trig_s) begin
            publish_s    = 1'b1;
            pub_period_s = cnt_inc_s;
            pub_peak_s   = pk_max_s;
        end
`ifdef TONE_MONITOR_TIMEOUT_EN
        else if (timeout_hit_s) begin
            publish_s     = 1'b1;
            pub_period_s  = 16'd0;
            pub_peak_s    = pk_r;
            pub_timeout_s = 1'b1;
        end
`endif
        else begin
            publish_s = 1'b0;
        end
    end

    // Measurement FSM, counters and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= SEEK;
            armed_r   <= 1'b0;
            cnt_r     <= 16'd0;
            pk_r      <= 16'sd0;
            period_r  <= 16'd0;
            peak_r    <= 16'sd0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
`ifdef TONE_MONITOR_TIMEOUT_EN
            timeout_r <= 1'b0;
`endif
        end else begin
            if (bus.en) begin
                if (trig_s) begin
                    armed_r <= 1'b0;
                end else if (arm_hit_s) begin
                    armed_r <= 1'b1;
                end else begin
                    armed_r <= armed_r;
                end
                case (state_r)
                    SEEK: begin
                        if (trig_s) begin
                            state_r <= LOCK;
                            cnt_r   <= 16'd0;
                            pk_r    <= din_s;
                        end
                    end
                    LOCK: begin
                        if (trig_s) begin
                            cnt_r <= 16'd0;
                            pk_r  <= din_s;
`ifdef TONE_MONITOR_TIMEOUT_EN
                        end else if (timeout_hit_s) begin
                            state_r <= SEEK;
                            armed_r <= 1'b0;
                            cnt_r   <= 16'd0;
`endif
                        end else begin
                            cnt_r <= cnt_inc_s;
                            pk_r  <= pk_max_s;
                        end
                    end
                    default: begin
                        state_r <= SEEK;
                    end
                endcase
            end

            // A publish always wins over a same-cycle ack; overrun only when
            // the pending result was not being acknowledged.
            if (publish_s) begin
                valid_r  <= 1'b1;
                period_r <= pub_period_s;
                peak_r   <= pub_peak_s;
`ifdef TONE_MONITOR_TIMEOUT_EN
                timeout_r <= pub_timeout_s;
`endif
                if (valid_r && !bus.ack) begin
                    overrun_r <= 1'b1;
                end
            end else if (bus.ack && valid_r) begin
                valid_r   <= 1'b0;
                overrun_r <= 1'b0;
            end
        end
    end

    assign bus.period  = period_r;
    assign bus.peak    = peak_r;
    assign bus.valid   = valid_r;
    assign bus.overrun = overrun_r;
`ifdef TONE_MONITOR_TIMEOUT_EN
    assign bus.timeout = timeout_r;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tone_monitor.sv
// -----------------------------------------------------------------------------
// tb_tone_monitor
// Directed tone scenarios plus randomized traffic, every cycle compared
// against a sample-history reference model of the tone monitor.
// -----------------------------------------------------------------------------
module tb_tone_monitor;

    localparam int HYST = 4096;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    tone_monitor_if bus ();

    tone_monitor #(.HYST(HYST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference model: plain bookkeeping of the sample history.
    bit m_armed;
    bit m_locked;
    int m_since;   // en samples since last trigger (trigger excluded)
    int m_wmax;    // max over trigger sample and samples since
    int m_valid, m_period, m_peak, m_overrun, m_timeout;

    function automatic void model_reset();
        m_armed = 0; m_locked = 0; m_since = 0; m_wmax = 0;
        m_valid = 0; m_period = 0; m_peak = 0; m_overrun = 0; m_timeout = 0;
    endfunction

    function automatic void model_step(input logic e, input logic [15:0] d, input logic a);
        bit pub;
        bit trig;
        int s, rp, rk, rt, old_wmax;
        pub = 0; rp = 0; rk = 0; rt = 0;
        if (e) begin
            s    = $signed(d);
            trig = m_armed && (s >= HYST);
            if (trig) m_armed = 0;
            else if (s <= -HYST) m_armed = 1;
            if (trig) begin
                if (m_locked) begin
                    pub = 1;
                    rp  = (m_since + 1 > 65535) ? 65535 : m_since + 1;
                    rk  = (s > m_wmax) ? s : m_wmax;
                end
                m_locked = 1; m_since = 0; m_wmax = s;
            end else if (m_locked) begin
                old_wmax = m_wmax;
                m_since++;
                if (s > m_wmax) m_wmax = s;
`ifdef TONE_MONITOR_TIMEOUT_EN
                if (m_since == 65535) begin
                    pub = 1; rp = 0; rk = old_wmax; rt = 1;
                    m_locked = 0; m_armed = 0; m_since = 0;
                end
`endif
            end
        end
        if (pub) begin
            if (m_valid == 1 && !a) m_overrun = 1;
            m_valid = 1; m_period = rp; m_peak = rk; m_timeout = rt;
        end else if (a && m_valid == 1) begin
            m_valid = 0; m_overrun = 0;
        end
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_model();
        check("valid",   int'(bus.valid),   m_valid);
        check("period",  int'(bus.period),  m_period);
        check("peak",    int'($signed(bus.peak)), m_peak);
        check("overrun", int'(bus.overrun), m_overrun);
        check("timeout", int'(bus.timeout), m_timeout);
    endtask

    // One clock: drive inputs, clock, then compare against the model.
    task automatic step(input logic e, input logic [15:0] d, input logic a);
        bus.en = e; bus.din = d; bus.ack = a;
        @(posedge clk);
        #1;
        model_step(e, d, a);
        check_model();
    endtask

    function automatic logic [15:0] tone(input int n);
        int i, v;
        i = n % 100;
        if (i < 10)       v = i * 400;
        else if (i == 20) v = 8192;
        else if (i < 20)  v = 4096 + (i - 10) * 409;
        else if (i < 56)  v = 8192 - (i - 20) * 350;
        else if (i < 80)  v = -4096 - (i - 56) * 170;
        else              v = -8192 + (i - 80) * 400;
        return v[15:0];
    endfunction

    // Stream tone samples from..to, with 'gap' idle clocks before each.
    task automatic tone_run(input int from, input int to, input int gap, input logic a);
        for (int n = from; n <= to; n++) begin
            repeat (gap) step(1'b0, 16'($urandom), a);
            step(1'b1, tone(n), a);
        end
    endtask

    // Asynchronous reset pulse in the middle of a cycle.
    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_valid",  int'(bus.valid),  0);
        check("rst_period", int'(bus.period), 0);
        check("rst_peak",   int'(bus.peak),   0);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; n_total = 0; n_pass = 0;
        bus.en = 1'b0; bus.din = 16'd0; bus.ack = 1'b0;
        model_reset();
        #12;
        check("reset_valid",   int'(bus.valid),   0);
        check("reset_period",  int'(bus.period),  0);
        check("reset_peak",    int'(bus.peak),    0);
        check("reset_overrun", int'(bus.overrun), 0);
        check("reset_timeout", int'(bus.timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous tone, ack held high.
        tone_run(0, 110, 0, 1'b1);
        check("first_trig_no_result", int'(bus.valid), 0);
        tone_run(111, 210, 0, 1'b1);
        check("res1_valid",  int'(bus.valid),  1);
        check("res1_period", int'(bus.period), 100);
        check("res1_peak",   int'(bus.peak),   8192);
        tone_run(211, 211, 0, 1'b1);
        check("res1_pulse",  int'(bus.valid),  0);
        tone_run(212, 310, 0, 1'b1);
        check("res2_period", int'(bus.period), 100);
        tone_run(311, 410, 0, 1'b1);
        check("res3_peak",   int'(bus.peak),   8192);

        // Tone with en on every third clock.
        async_reset();
        tone_run(0, 210, 2, 1'b1);
        check("sparse_valid",  int'(bus.valid),  1);
        check("sparse_period", int'(bus.period), 100);
        check("sparse_peak",   int'(bus.peak),   8192);

        // Reset mid-measurement, re-lock at 210, result at 310.
        async_reset();
        tone_run(0, 150, 0, 1'b1);
        async_reset();
        tone_run(151, 210, 0, 1'b1);
        check("relock_no_result", int'(bus.valid), 0);
        tone_run(211, 310, 0, 1'b1);
        check("relock_valid",  int'(bus.valid),  1);
        check("relock_period", int'(bus.period), 100);

        // Overrun: two results without ack, then a single ack.
        async_reset();
        tone_run(0, 310, 0, 1'b0);
        check("ovr_set",   int'(bus.overrun), 1);
        check("ovr_valid", int'(bus.valid),   1);
        step(1'b0, 16'd0, 1'b1);
        check("ack_valid",   int'(bus.valid),   0);
        check("ack_overrun", int'(bus.overrun), 0);

        // Ack on the exact publish cycle of a new result.
        tone_run(311, 509, 0, 1'b0);
        tone_run(510, 510, 0, 1'b1);
        check("simul_valid",   int'(bus.valid),   1);
        check("simul_overrun", int'(bus.overrun), 0);
        check("simul_period",  int'(bus.period),  100);

        // Randomized traffic.
        async_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 2 == 0) step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
            else            step(1'($urandom_range(0, 3) != 0), tone(i + int'($urandom_range(0, 3))), 1'($urandom_range(0, 1)));
        end

        // Long silence after lock.
        async_reset();
        tone_run(0, 110, 0, 1'b1);
        repeat (65535) step(1'b1, 16'd0, 1'b0);
`ifdef TONE_MONITOR_TIMEOUT_EN
        check("to_valid",   int'(bus.valid),   1);
        check("to_timeout", int'(bus.timeout), 1);
        check("to_period",  int'(bus.period),  0);
`else
        check("sil_valid",   int'(bus.valid),   0);
        check("sil_timeout", int'(bus.timeout), 0);
`endif
        repeat (64) step(1'b1, 16'd0, 1'b1);
        tone_run(111, 210, 0, 1'b1);
`ifdef TONE_MONITOR_TIMEOUT_EN
        check("to_relock_no_result", int'(bus.valid), 0);
`else
        check("sat_valid",  int'(bus.valid),  1);
        check("sat_period", int'(bus.period), 65535);
        check("sat_peak",   int'(bus.peak),   8192);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tone_monitor.md
# tone_monitor

Sample-stream analyzer at the consuming end of the tone generator's 16-bit sample bus. It watches signed samples qualified by `en`, finds positive-going zero crossings with hysteresis, and measures the period in samples between consecutive crossings. It also captures the positive peak over each period. Results go to the control side through a valid/ack handshake, with overrun reporting.

## Interface
- `HYST`, 4096: hysteresis threshold, unsigned, 1..32767; arm level is `-HYST`, trigger level is `+HYST`.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `en`  in  1  sample strobe; `din` is consumed only on cycles with `en`=1.
- `din`  in  16  signed two's-complement sample.
- `ack`  in  1  result acknowledge from the consumer.
- `period`  out  16  samples between the last two triggers, unsigned.
- `peak`  out  16  signed maximum sample over the measured window.
- `valid`  out  1  result pending.
- `overrun`  out  1  sticky flag: a result was overwritten while still unacknowledged.
- `timeout`  out  1  the current result is a timeout report (see Configuration).

## Operation
- Crossing detection, evaluated on `en` samples only:
  - Sample ≤ `-HYST` sets `armed`.
  - Sample ≥ `+HYST` while `armed` is a trigger, which clears `armed`.
  - All comparisons are signed, 16-bit.
- State machine:
  - `SEEK` (reset state): trigger → `LOCK`; no result is produced.
  - `LOCK`: trigger → publish result, stay in `LOCK`.
- Counter `cnt` (16 bit):
  - Cleared to 0 on every trigger sample.
  - +1 on every other `en` sample in `LOCK`.
  - Saturates at 16'hFFFF.
- Published `period` = `cnt`+1, saturating at 16'hFFFF.
- Running max `pk`:
  - Loaded with `din` on a trigger sample.
  - Otherwise, on each `en` sample in `LOCK`, updated to max(`pk`, `din`).
  - Published `peak` = max(`pk`, trigger sample). The window covers the sample after the previous trigger through the current trigger, inclusive.
- Handshake:
  - Publishing sets `valid`=1 and loads `period`/`peak`/`timeout`.
  - `ack` with `valid`=1 clears `valid`. `ack` while `valid`=0 is ignored.
- Simultaneous publish and `ack` in the same cycle: the new result wins, `valid` stays 1, `overrun` is not set.
- Publish while `valid`=1 and `ack`=0: outputs are overwritten and `overrun` is set.
- `overrun` clears only on an accepted `ack` with no simultaneous overwrite, or on reset.
- Reset values: `period`=0, `peak`=0, `valid`=0, `overrun`=0, `timeout`=0, `cnt`=0, `pk`=0, `armed`=0, state `SEEK`.
- Reset mid-measurement discards all partial state immediately, asynchronously.

## Timing
- All outputs are registered.
- `valid`/`period`/`peak` update on the rising edge that samples the trigger `en` cycle. They are visible in the following cycle, so latency is 1 clock from the trigger sample.
- `valid` deasserts on the edge that samples `ack`=1.
- Back-to-back `en` on every clock is supported with no stalls, at one sample per clock.
- `din` is don't-care when `en`=0. `cnt`, `pk` and `armed` hold on such cycles.

## Configuration
- `TONE_MONITOR_TIMEOUT_EN` defined:
  - In `LOCK`, when `cnt` reaches 16'hFFFF on an `en` sample, publish `period`=0, `peak`=`pk`, `timeout`=1, then return to `SEEK` with `armed` cleared.
  - Normal publishes load `timeout`=0.
  - The handshake and overrun rules apply unchanged.
- Not defined:
  - `timeout` is tied to 0.
  - `cnt` saturates and `LOCK` persists indefinitely.
  - The next trigger reports `period`=16'hFFFF.

## Test plan
- Tone table driven with `en` every clock, `HYST`=4096, `ack` held 1:
  - Arm at table index 56, first trigger at sample 110 (index 10), no result.
  - Trigger at sample 210 → `period`=100, `peak`=8192, `valid` pulses for 1 cycle.
  - Results repeat every 100 samples.
- Same stream with `en` asserted every 3rd clock → identical `period`=100 and `peak`=8192; `cnt` is unchanged by idle clocks.
- `ack` held 0 across two results → second result overwrites the first, `overrun`=1. One `ack` cycle → `valid`=0, `overrun`=0.
- Drive `ack`=1 on the exact cycle a new result publishes → `valid` stays 1, `overrun` stays 0, new `period` is visible.
- Assert `rst_n`=0 for one cycle at sample 150 → all outputs 0 immediately. Next result appears at sample 310 with `period`=100 (re-lock at 210).
- With `TONE_MONITOR_TIMEOUT_EN`: after lock, hold `din`=0 with `en`=1 → after 65535 samples, `valid`=1, `timeout`=1, `period`=0, FSM back in `SEEK`. Without the macro: `valid` stays 0, and resuming the tone yields `period`=16'hFFFF.
